// File: rtl/cla_serial_subtractor.sv
// rtl/cla_serial_subtractor.sv - multi-cycle subtractor, one 4-bit borrow-lookahead slice per clock
// Optional zero flag output enabled by defining CLA_SUB_ZERO_FLAG_EN.
module cla_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef CLA_SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [CW+1:0]     idx;
    logic [3:0]        na, nb, g, p, sum;
    logic              c0, c1, c2, c3, c4;

    // Subtraction as a + ~b + ~borrow; carries flattened to two-level lookahead.
    always_comb begin
        idx = {cnt_q, 2'b00};
        na  = a_q[idx +: 4];
        nb  = ~b_q[idx +: 4];
        g   = na & nb;
        p   = na ^ nb;
        c0  = ~borrow_q;
        c1  = g[0] | (p[0] & c0);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);
        sum = p ^ {c3, c2, c1, c0};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    zero_d   = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d[idx +: 4] = sum;
                borrow_d         = ~c4;
                zero_d           = zero_q & (sum == 4'h0);
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == CW'(NIB - 1)) begin
                    cnt_d   = '0;
                    bout_d  = ~c4;
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[3] ^ a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
`ifdef CLA_SUB_ZERO_FLAG_EN
    // The accumulator runs during BUSY, so only expose it with the result.
    assign zero      = zero_q & (state_q == DONE);
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// tb/tb_cla_serial_subtractor.sv - directed bench for cla_serial_subtractor (WIDTH=16)
module tb_cla_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
`ifdef CLA_SUB_ZERO_FLAG_EN
    logic        zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cla_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef CLA_SUB_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, then count edges until out_valid.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("in_ready_low_busy", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int edges;
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, edges, 32'd4);
    endtask

    task automatic check_res(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
        start_op(av, bv, bi);
        wait_done(tag);
        check_res(tag, ed, eb, eo);
        handoff(tag);
    endtask

    initial begin
        int saw_valid;
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_res("reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run("ovf_neg",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run("ovf_pos",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        start_op(16'h0100, 16'h00FF, 1'b1);
        wait_done("xborrow1");
        check_res("xborrow1", 16'h0000, 1'b0, 1'b0);
`ifdef CLA_SUB_ZERO_FLAG_EN
        chk("xborrow1_zero", {31'd0, zero}, 32'd1);
`endif
        handoff("xborrow1");

        start_op(16'h0100, 16'h00FF, 1'b0);
        wait_done("xborrow0");
        check_res("xborrow0", 16'h0001, 1'b0, 1'b0);
`ifdef CLA_SUB_ZERO_FLAG_EN
        chk("xborrow0_zero", {31'd0, zero}, 32'd0);
`endif
        handoff("xborrow0");

        // Backpressure: new operands offered while the result is held.
        start_op(16'h00F0, 16'h000F, 1'b0);
        wait_done("bp");
        a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check_res("bp_hold", 16'h00E1, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done("bp_new");
        check_res("bp_new", 16'h4444, 1'b0, 1'b0);
        handoff("bp_new");

        // Reset after two BUSY edges: partial diff is 0x00EE at that point.
        start_op(16'hFFFF, 16'h1111, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_res("rst_mid", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) saw_valid = 1;
        end
        chk("rst_no_stale_result", saw_valid, 32'd0);
        chk("rst_after_in_ready", {31'd0, in_ready}, 32'd1);

        run("post_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_serial_subtractor.md
Name: cla_serial_subtractor

Overview:
- Multi-cycle wide subtractor: diff = a - b - bin over WIDTH bits.
- One 4-bit borrow-lookahead slice per clock. Borrow is held in a register between nibbles.
- Companion to the team's combinational 4-bit carry-lookahead adder. Used where wide subtraction must reuse one small lookahead slice instead of a full-width tree.
- Operands enter on a valid/ready handshake; results leave on a valid/ready handshake.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff, bout and ovf are valid
- out_ready  input  1  downstream accepts the result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  unsigned borrow-out; 1 when a < b + bin
- ovf  output  1  signed overflow of the two's-complement subtraction

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - diff=0, bout=0, ovf=0, out_valid=0.
  - Nibble counter, borrow register and operand registers all cleared.
  - in_ready=1, since it is decoded from state.
- IDLE -> BUSY on a clock edge with in_valid=1:
  - Register a, b, bin.
  - Set borrow register = bin, nibble counter = 0.
  - Drive in_ready low from the next cycle.
- BUSY, one edge per nibble i (i = 0 .. WIDTH/4-1):
  - Slice computes a[4i+3:4i] + ~b[4i+3:4i] + ~borrow.
  - Carry lookahead inside the slice: g = a & ~b, p = a ^ ~b, carries flattened in two-level form. No ripple.
  - Sum nibble is written to diff[4i+3:4i].
  - borrow <= ~carry_out.
  - Counter increments.
- On the edge processing the last nibble:
  - State -> DONE, out_valid=1.
  - bout = final borrow.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
- Latency: out_valid rises exactly WIDTH/4 clock edges after the accepting edge (4 for WIDTH=16).
- DONE:
  - diff, bout and ovf are held stable until an edge with out_ready=1; then state -> IDLE and out_valid=0.
  - No same-cycle re-accept: in_ready stays 0 in DONE. Next acceptance is possible at the earliest one cycle after result handoff.
  - Throughput: at most one result per WIDTH/4 + 2 cycles.
- in_valid while BUSY or DONE: ignored, and operands are not captured. The upstream must hold its data until in_ready=1.
- diff is partially updated while BUSY and is only meaningful while out_valid=1.
- Reset mid-BUSY or mid-DONE: the operation is aborted and all outputs are cleared as at reset. No result is produced afterwards.

Optional Feature:
- CLA_SUB_ZERO_FLAG_EN defined:
  - Adds output port zero (1 bit).
  - zero=1 in DONE when diff == 0. It is held with the other results and reset to 0.
  - It is accumulated per nibble: zero = AND of (sum nibble == 0) over all nibbles. No final WIDTH-bit compare.
- Undefined: port zero and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic subtraction (WIDTH=16): a=0x1234, b=0x0234, bin=0 accepted -> out_valid exactly 4 edges later; diff=0x1000, bout=0, ovf=0.
- Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
- Signed overflow: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
- Cross-nibble borrow with borrow-in: a=0x0100, b=0x00FF, bin=1 -> diff=0x0000, bout=0, ovf=0.
  - With CLA_SUB_ZERO_FLAG_EN: zero=1.
  - Repeat with bin=0: diff=0x0001, zero=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> diff/bout/ovf stable, in_ready=0, new operands not captured.
  - Then out_ready=1 -> IDLE next cycle; the new operands are accepted on the following edge.
- Reset mid-operation: assert rst_n=0 after 2 BUSY edges -> diff=0, bout=0, ovf=0, out_valid=0 immediately (asynchronous).
  - After release: in_ready=1 and no stale result ever appears.
